move_score_selector: RTL and testbench
======================================

Name: move_score_selector

Overview:
- Sits directly downstream of the board analyzer BRAM block.
- Consumes one feature record per candidate placement: lines cleared, holes, aggregate height, bumpiness.
- Computes a weighted signed score for each record and tracks the best-scoring move over a batch.
- Presents the winning move ID and its score to the AXI-Lite register bank for software and the move driver.

Parameters:
- MOVE_ID_W, 6, width of the candidate move identifier (rotation x column, up to 64 moves).
- FEAT_W, 8, width of the holes, aggregate-height and bumpiness features (unsigned).
- WGT_W, 16, width of each signed weight.
- SCORE_W, 32, width of the signed score accumulator and output.

Ports:
- ACLK  in  1  system clock.
- ARESETN  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; opens a new batch.
- w_lines, w_holes, w_height, w_bump  in  WGT_W each  signed weights; sampled on start and held for the batch.
- in_valid  in  1  feature record valid.
- in_ready  out  1  block can accept a record.
- in_move_id  in  MOVE_ID_W  candidate identifier.
- in_lines  in  3  lines cleared, 0..4.
- in_holes, in_height, in_bump  in  FEAT_W each  unsigned features.
- in_illegal  in  1  placement invalid; the record is counted but never selected.
- in_last  in  1  final record of the batch.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed.
- res_move_id  out  MOVE_ID_W  best move.
- res_score  out  SCORE_W  best score, signed.
- res_found  out  1  at least one legal candidate was seen.
- res_count  out  MOVE_ID_W+1  number of records accepted in the batch.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (asynchronous, ARESETN=0): state=IDLE. All outputs 0: in_ready, res_valid, res_move_id, res_score, res_found, res_count, busy. Pipeline valids cleared. Asserting reset mid-batch abandons the batch without producing a result.
- States:
  - IDLE: waits for start. On start, latch the weights, clear best/found/count, go to ACCUM.
  - ACCUM: in_ready=1. A record is accepted on in_valid&in_ready. When the accepted record has in_last=1, go to DRAIN.
  - DRAIN: in_ready=0. Wait until the pipeline is empty, which takes 2 cycles after the last accept. Then go to DONE.
  - DONE: res_valid=1. Outputs are held stable until res_ready=1, then go to IDLE. res_valid and res_ready high in the same cycle is the handshake.
- start is ignored in any state other than IDLE. start and res_ready high together in DONE: the result completes and start is ignored (one-cycle gap required).
- Pipeline: 2 registered stages.
  - Stage 1: four signed products. Each feature is zero-extended by one bit, then multiplied by its weight.
  - Stage 2: the products are summed into a SCORE_W signed score, sign-extended. Then the compare-and-update is performed.
  - Score = w_lines*lines + w_holes*holes + w_height*height + w_bump*bump. Weights are normally negative for holes, height and bumpiness; the block applies no sign convention.
- Width: the worst-case product magnitude is 2^15*255, about 2^23. The sum of four fits in 26 bits. SCORE_W=32 never overflows, so no saturation logic.
- Selection rule:
  - A record updates best only if it is legal and either found=0 or score > best_score (strictly greater).
  - Ties keep the earlier-arriving move.
  - Illegal records increment count only.
- res_count increments on every accept. A batch of 64 records gives count=64, hence the extra bit.
- If every record is illegal: res_found=0, res_move_id=0, res_score=0.
- Back-to-back accepts every cycle are required; no bubbles in ACCUM.

Decomposition:
- Shared package board_analyzer_pkg:
  - state enum {IDLE, ACCUM, DRAIN, DONE};
  - feature record struct (move_id, lines, holes, height, bump, illegal, last);
  - constants for board width (10) and height (20);
  - MAX_LINES=4.
- One sub-module, move_score_mac: the 2-stage weighted-sum pipeline, with valid and sideband passed through. The top level owns the FSM, the compare logic and the result registers.

Test Plan:
- Weights (lines=+76, holes=-35, height=-51, bump=-18). Three legal records: id3 (1,0,20,4), id7 (0,0,10,2), id9 (2,1,30,6).
  - Required: id7 wins with score -546; count=3; found=1.
- Tie case: two legal records with identical features, ids 5 then 12.
  - Required: res_move_id=5.
- All records illegal: 4 records with in_illegal=1.
  - Required: res_found=0, res_count=4, res_score=0.
- 64 back-to-back records, in_valid held high, with id 40 holding the uniquely highest score.
  - Required: no in_ready drops; res_move_id=40; res_count=64.
- Hold the result: hold res_ready=0 for 10 cycles in DONE.
  - Required: outputs stable throughout.
  - Pulse start during DONE → ignored.
  - Assert res_ready → IDLE next cycle.
- Pull ARESETN low mid-ACCUM, asynchronously between clock edges.
  - Required: outputs immediately 0, state IDLE.
  - After release, a new batch of one record (id 2) returns id 2.

Source files
------------

// File: rtl/board_analyzer_pkg.sv
// Shared types and constants for the board analyzer / move selection datapath.
// Feature record layout and the selector FSM states live here.
package board_analyzer_pkg;

  localparam int MOVE_ID_W = 6;
  localparam int FEAT_W    = 8;
  localparam int WGT_W     = 16;
  localparam int SCORE_W   = 32;
  localparam int LINES_W   = 3;
  localparam int BOARD_W   = 10;
  localparam int BOARD_H   = 20;
  localparam int MAX_LINES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [MOVE_ID_W-1:0] move_id;
    logic [LINES_W-1:0]   lines;
    logic [FEAT_W-1:0]    holes;
    logic [FEAT_W-1:0]    height;
    logic [FEAT_W-1:0]    bump;
    logic                 illegal;
    logic                 last;
  } feat_rec_t;

  // Sideband that travels alongside the score through the pipeline.
  typedef struct packed {
    logic [MOVE_ID_W-1:0] move_id;
    logic                 illegal;
    logic                 last;
  } side_t;

  function automatic side_t side_of(feat_rec_t r);
    side_t s;
    s.move_id = r.move_id;
    s.illegal = r.illegal;
    s.last    = r.last;
    return s;
  endfunction

endpackage

// File: rtl/move_score_selector_if.sv
// Record-in / result-out bundle of the move score selector.
// master = upstream analyzer + result consumer side, slave = the selector.
interface move_score_selector_if;
  import board_analyzer_pkg::*;

  logic                      start;
  logic signed [WGT_W-1:0]   w_lines;
  logic signed [WGT_W-1:0]   w_holes;
  logic signed [WGT_W-1:0]   w_height;
  logic signed [WGT_W-1:0]   w_bump;

  logic                      in_valid;
  logic                      in_ready;
  logic [MOVE_ID_W-1:0]      in_move_id;
  logic [LINES_W-1:0]        in_lines;
  logic [FEAT_W-1:0]         in_holes;
  logic [FEAT_W-1:0]         in_height;
  logic [FEAT_W-1:0]         in_bump;
  logic                      in_illegal;
  logic                      in_last;

  logic                      res_valid;
  logic                      res_ready;
  logic [MOVE_ID_W-1:0]      res_move_id;
  logic signed [SCORE_W-1:0] res_score;
  logic                      res_found;
  logic [MOVE_ID_W:0]        res_count;
  logic                      busy;

  modport master (
    output start, w_lines, w_holes, w_height, w_bump,
    output in_valid, in_move_id, in_lines, in_holes, in_height, in_bump,
    output in_illegal, in_last, res_ready,
    input  in_ready, res_valid, res_move_id, res_score, res_found, res_count, busy
  );

  modport slave (
    input  start, w_lines, w_holes, w_height, w_bump,
    input  in_valid, in_move_id, in_lines, in_holes, in_height, in_bump,
    input  in_illegal, in_last, res_ready,
    output in_ready, res_valid, res_move_id, res_score, res_found, res_count, busy
  );

endinterface

// File: rtl/move_score_mac.sv
// Weighted-sum datapath: registered feature*weight products, then their signed sum.
// The sum is presented combinationally so the consumer's register forms the second stage.
module move_score_mac
  import board_analyzer_pkg::*;
(
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic                      in_vld,
  input  feat_rec_t                 in_rec,
  input  logic signed [WGT_W-1:0]   w_lines,
  input  logic signed [WGT_W-1:0]   w_holes,
  input  logic signed [WGT_W-1:0]   w_height,
  input  logic signed [WGT_W-1:0]   w_bump,
  output logic                      out_vld,
  output side_t                     out_side,
  output logic signed [SCORE_W-1:0] out_score
);

  // One extra bit holds the zero-extended feature as a non-negative signed operand.
  localparam int PROD_W = WGT_W + FEAT_W + 1;

  logic signed [PROD_W-1:0] p_lines_d, p_holes_d, p_height_d, p_bump_d;
  logic signed [PROD_W-1:0] p_lines_q, p_holes_q, p_height_q, p_bump_q;
  logic                     vld_q;
  side_t                    side_q;

  always_comb begin
    p_lines_d  = PROD_W'(w_lines)  * PROD_W'($signed({1'b0, in_rec.lines}));
    p_holes_d  = PROD_W'(w_holes)  * PROD_W'($signed({1'b0, in_rec.holes}));
    p_height_d = PROD_W'(w_height) * PROD_W'($signed({1'b0, in_rec.height}));
    p_bump_d   = PROD_W'(w_bump)   * PROD_W'($signed({1'b0, in_rec.bump}));
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      vld_q      <= 1'b0;
      side_q     <= '0;
      p_lines_q  <= '0;
      p_holes_q  <= '0;
      p_height_q <= '0;
      p_bump_q   <= '0;
    end else begin
      vld_q <= in_vld;
      if (in_vld) begin
        side_q     <= side_of(in_rec);
        p_lines_q  <= p_lines_d;
        p_holes_q  <= p_holes_d;
        p_height_q <= p_height_d;
        p_bump_q   <= p_bump_d;
      end
    end
  end

  // Four 25-bit products sum to at most 27 bits, so the 32-bit total cannot wrap.
  assign out_score = SCORE_W'(p_lines_q) + SCORE_W'(p_holes_q)
                   + SCORE_W'(p_height_q) + SCORE_W'(p_bump_q);
  assign out_vld   = vld_q;
  assign out_side  = side_q;

endmodule

// File: rtl/move_score_selector.sv
// Scores each candidate placement and keeps the best legal one of a batch for software.
// Result is ready 2 cycles after the last accept and is held until res_ready.
module move_score_selector
  import board_analyzer_pkg::*;
(
  input  logic                 ACLK,
  input  logic                 ARESETN,
  move_score_selector_if.slave sel_if
);

  localparam int CNT_W = MOVE_ID_W + 1;

  state_e                    state_q, state_d;
  logic signed [WGT_W-1:0]   w_lines_q, w_holes_q, w_height_q, w_bump_q;
  logic [MOVE_ID_W-1:0]      best_id_q, best_id_d;
  logic signed [SCORE_W-1:0] best_score_q, best_score_d;
  logic                      found_q, found_d;
  logic [CNT_W-1:0]          count_q, count_d;

  logic                      accept;
  logic                      batch_open;
  logic                      take;
  feat_rec_t                 in_rec;
  logic                      mac_vld;
  side_t                     mac_side;
  logic signed [SCORE_W-1:0] mac_score;

  assign accept     = sel_if.in_valid && (state_q == ACCUM);
  assign batch_open = sel_if.start && (state_q == IDLE);

  always_comb begin
    in_rec         = '0;
    in_rec.move_id = sel_if.in_move_id;
    in_rec.lines   = sel_if.in_lines;
    in_rec.holes   = sel_if.in_holes;
    in_rec.height  = sel_if.in_height;
    in_rec.bump    = sel_if.in_bump;
    in_rec.illegal = sel_if.in_illegal;
    in_rec.last    = sel_if.in_last;
  end

  move_score_mac u_mac (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .in_vld    (accept),
    .in_rec    (in_rec),
    .w_lines   (w_lines_q),
    .w_holes   (w_holes_q),
    .w_height  (w_height_q),
    .w_bump    (w_bump_q),
    .out_vld   (mac_vld),
    .out_side  (mac_side),
    .out_score (mac_score)
  );

  // Strictly greater: on a tie the earlier-arriving move stays selected.
  assign take = mac_vld && !mac_side.illegal && (!found_q || (mac_score > best_score_q));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (sel_if.start) state_d = ACCUM;
      ACCUM: if (accept && sel_if.in_last) state_d = DRAIN;
      // No accepts happen in DRAIN, so a flagged-last record in stage 1 is the final one.
      DRAIN: if (mac_vld && mac_side.last) state_d = DONE;
      DONE:  if (sel_if.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    best_id_d    = best_id_q;
    best_score_d = best_score_q;
    found_d      = found_q;
    count_d      = count_q;
    if (batch_open) begin
      best_id_d    = '0;
      best_score_d = '0;
      found_d      = 1'b0;
      count_d      = '0;
    end else begin
      if (take) begin
        best_id_d    = mac_side.move_id;
        best_score_d = mac_score;
        found_d      = 1'b1;
      end
      if (accept) count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_lines_q  <= '0;
      w_holes_q  <= '0;
      w_height_q <= '0;
      w_bump_q   <= '0;
    end else if (batch_open) begin
      w_lines_q  <= sel_if.w_lines;
      w_holes_q  <= sel_if.w_holes;
      w_height_q <= sel_if.w_height;
      w_bump_q   <= sel_if.w_bump;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q      <= IDLE;
      best_id_q    <= '0;
      best_score_q <= '0;
      found_q      <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      best_id_q    <= best_id_d;
      best_score_q <= best_score_d;
      found_q      <= found_d;
      count_q      <= count_d;
    end
  end

  assign sel_if.in_ready    = (state_q == ACCUM);
  assign sel_if.res_valid   = (state_q == DONE);
  assign sel_if.busy        = (state_q != IDLE);
  assign sel_if.res_move_id = best_id_q;
  assign sel_if.res_score   = best_score_q;
  assign sel_if.res_found   = found_q;
  assign sel_if.res_count   = count_q;

endmodule

// File: tb/tb_move_score_selector.sv
// Self-checking bench for move_score_selector: vector table, directed corner cases,
// and randomized batches compared against a list-based best-move model.
module tb_move_score_selector;
  import board_analyzer_pkg::*;

  logic ACLK = 1'b0;
  logic ARESETN;
  always #5 ACLK = ~ACLK;

  move_score_selector_if sel_if ();

  move_score_selector dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .sel_if  (sel_if)
  );

  int checks   = 0;
  int failures = 0;

  feat_rec_t batch_q[$];
  int wl, wh, wht, wb;

  typedef struct {
    int     wl, wh, wht, wb;
    int     id, lines, holes, height, bump;
    bit     illegal;
    bit     exp_found;
    int     exp_id;
    longint exp_score;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic feat_rec_t mk(input int id, input int l, input int h, input int ht,
                                   input int b, input bit ill);
    feat_rec_t r;
    r.move_id = MOVE_ID_W'(id);
    r.lines   = LINES_W'(l);
    r.holes   = FEAT_W'(h);
    r.height  = FEAT_W'(ht);
    r.bump    = FEAT_W'(b);
    r.illegal = ill;
    r.last    = 1'b0;
    return r;
  endfunction

  function automatic longint rec_score(input feat_rec_t r);
    return longint'(wl) * longint'(r.lines) + longint'(wh) * longint'(r.holes)
         + longint'(wht) * longint'(r.height) + longint'(wb) * longint'(r.bump);
  endfunction

  // Best legal move of the list: first strictly-highest score wins.
  task automatic model(output bit f, output longint id, output longint sc, output longint cnt);
    f = 1'b0; id = 0; sc = 0;
    foreach (batch_q[i]) begin
      if (!batch_q[i].illegal && (!f || rec_score(batch_q[i]) > sc)) begin
        f  = 1'b1;
        id = longint'(batch_q[i].move_id);
        sc = rec_score(batch_q[i]);
      end
    end
    cnt = batch_q.size();
  endtask

  task automatic drive_idle();
    sel_if.start = 0; sel_if.in_valid = 0; sel_if.res_ready = 0;
    sel_if.w_lines = 0; sel_if.w_holes = 0; sel_if.w_height = 0; sel_if.w_bump = 0;
    sel_if.in_move_id = 0; sel_if.in_lines = 0; sel_if.in_holes = 0;
    sel_if.in_height = 0; sel_if.in_bump = 0; sel_if.in_illegal = 0; sel_if.in_last = 0;
  endtask

  task automatic set_rec(input feat_rec_t r, input bit last);
    sel_if.in_move_id = r.move_id;
    sel_if.in_lines   = r.lines;
    sel_if.in_holes   = r.holes;
    sel_if.in_height  = r.height;
    sel_if.in_bump    = r.bump;
    sel_if.in_illegal = r.illegal;
    sel_if.in_last    = last;
  endtask

  task automatic open_batch();
    sel_if.w_lines  = WGT_W'(wl);
    sel_if.w_holes  = WGT_W'(wh);
    sel_if.w_height = WGT_W'(wht);
    sel_if.w_bump   = WGT_W'(wb);
    sel_if.start    = 1;
    tick();
    sel_if.start    = 0;
  endtask

  // Starts a batch, feeds batch_q, returns once res_valid is seen (or a bound expires).
  task automatic run_batch(input string name, input bit b2b, output int cyc);
    int wt;
    open_batch();
    cyc = 0;
    foreach (batch_q[i]) begin
      if (!b2b && $urandom_range(0, 3) == 0) begin
        sel_if.in_valid = 0;
        repeat ($urandom_range(1, 2)) begin tick(); cyc++; end
      end
      set_rec(batch_q[i], i == batch_q.size() - 1);
      sel_if.in_valid = 1;
      wt = 0;
      while (!sel_if.in_ready && wt < 50) begin tick(); wt++; cyc++; end
      if (!sel_if.in_ready) begin
        checks++; failures++;
        $display("FAIL %s in_ready_timeout actual=0 required=1", name);
        sel_if.in_valid = 0;
        return;
      end
      tick(); cyc++;
    end
    sel_if.in_valid = 0;
    sel_if.in_last  = 0;
    wt = 0;
    while (!sel_if.res_valid && wt < 20) begin tick(); wt++; end
    chk({name, " res_valid"}, sel_if.res_valid, 1);
  endtask

  task automatic check_res(input string name);
    bit f; longint id, sc, cnt;
    model(f, id, sc, cnt);
    chk({name, " found"}, sel_if.res_found, f);
    chk({name, " move_id"}, sel_if.res_move_id, id);
    chk({name, " score"}, $signed(sel_if.res_score), sc);
    chk({name, " count"}, sel_if.res_count, cnt);
  endtask

  task automatic release_res(input int delay);
    repeat (delay) tick();
    sel_if.res_ready = 1;
    tick();
    sel_if.res_ready = 0;
  endtask

  initial begin
    int cyc;
    tbl[0] = '{76, -35, -51, -18,   3, 1,   0,  20,   4, 0, 1,  3, -1016};
    tbl[1] = '{76, -35, -51, -18,   9, 2,   1,  30,   6, 0, 1,  9, -1521};
    tbl[2] = '{32767, 32767, 32767, 32767,     63, 4, 255, 255, 255, 0, 1, 63,  25197823};
    tbl[3] = '{-32768, -32768, -32768, -32768,  1, 4, 255, 255, 255, 0, 1,  1, -25198592};
    tbl[4] = '{76, -35, -51, -18,  20, 3,   5,   5,   5, 1, 0,  0,     0};
    tbl[5] = '{0, 0, 0, 0,         33, 3,  10,  10,  10, 0, 1, 33,     0};
    tbl[6] = '{1, -1, 2, 3,        50, 0, 200,   1,   1, 0, 1, 50,  -195};

    drive_idle();
    ARESETN = 0;
    #12;
    chk("reset busy", sel_if.busy, 0);
    chk("reset in_ready", sel_if.in_ready, 0);
    chk("reset res_valid", sel_if.res_valid, 0);
    chk("reset res_found", sel_if.res_found, 0);
    chk("reset res_count", sel_if.res_count, 0);
    chk("reset res_move_id", sel_if.res_move_id, 0);
    chk("reset res_score", sel_if.res_score, 0);
    #11 ARESETN = 1;
    tick();

    // Single-record batches with hand-computed expectations.
    foreach (tbl[i]) begin
      wl = tbl[i].wl; wh = tbl[i].wh; wht = tbl[i].wht; wb = tbl[i].wb;
      batch_q = {};
      batch_q.push_back(mk(tbl[i].id, tbl[i].lines, tbl[i].holes, tbl[i].height,
                           tbl[i].bump, tbl[i].illegal));
      run_batch($sformatf("vec%0d", i), 1'b1, cyc);
      chk($sformatf("vec%0d found", i), sel_if.res_found, tbl[i].exp_found);
      chk($sformatf("vec%0d move_id", i), sel_if.res_move_id, tbl[i].exp_id);
      chk($sformatf("vec%0d score", i), $signed(sel_if.res_score), tbl[i].exp_score);
      chk($sformatf("vec%0d count", i), sel_if.res_count, 1);
      release_res(0);
    end

    // Three legal candidates, then hold the result with a stray start pulse.
    wl = 76; wh = -35; wht = -51; wb = -18;
    batch_q = {mk(3, 1, 0, 20, 4, 0), mk(7, 0, 0, 10, 2, 0), mk(9, 2, 1, 30, 6, 0)};
    run_batch("three", 1'b1, cyc);
    chk("three move_id", sel_if.res_move_id, 7);
    chk("three score", $signed(sel_if.res_score), -546);
    chk("three count", sel_if.res_count, 3);
    chk("three found", sel_if.res_found, 1);
    for (int k = 0; k < 10; k++) begin
      sel_if.start = (k == 4);
      tick();
      chk($sformatf("hold%0d res_valid", k), sel_if.res_valid, 1);
      chk($sformatf("hold%0d move_id", k), sel_if.res_move_id, 7);
      chk($sformatf("hold%0d score", k), $signed(sel_if.res_score), -546);
      chk($sformatf("hold%0d count", k), sel_if.res_count, 3);
    end
    sel_if.start = 0;
    release_res(0);
    chk("hold release busy", sel_if.busy, 0);
    chk("hold release res_valid", sel_if.res_valid, 0);

    // Tie keeps the first; start together with res_ready is dropped.
    batch_q = {mk(5, 1, 2, 3, 4, 0), mk(12, 1, 2, 3, 4, 0)};
    run_batch("tie", 1'b0, cyc);
    check_res("tie");
    chk("tie move_id5", sel_if.res_move_id, 5);
    sel_if.start = 1; sel_if.res_ready = 1;
    tick();
    sel_if.start = 0; sel_if.res_ready = 0;
    chk("start_with_ready busy", sel_if.busy, 0);
    tick();
    chk("start_with_ready idle", sel_if.busy, 0);

    // All illegal.
    batch_q = {mk(1, 4, 0, 0, 0, 1), mk(2, 0, 1, 1, 1, 1), mk(3, 2, 0, 5, 0, 1),
               mk(4, 1, 9, 9, 9, 1)};
    run_batch("illegal", 1'b1, cyc);
    chk("illegal found", sel_if.res_found, 0);
    chk("illegal count", sel_if.res_count, 4);
    chk("illegal score", sel_if.res_score, 0);
    chk("illegal move_id", sel_if.res_move_id, 0);
    release_res(2);

    // 64 back-to-back records; id 40 is the only positive score.
    batch_q = {};
    for (int i = 0; i < 64; i++) begin
      if (i == 40) batch_q.push_back(mk(i, 4, 0, 0, 0, 0));
      else batch_q.push_back(mk(i, 0, $urandom_range(1, 10), $urandom_range(10, 100),
                                $urandom_range(1, 20), 0));
    end
    run_batch("b2b", 1'b1, cyc);
    chk("b2b accept_cycles", cyc, 64);
    chk("b2b move_id", sel_if.res_move_id, 40);
    chk("b2b count", sel_if.res_count, 64);
    check_res("b2b");
    release_res(1);

    // Asynchronous reset between edges in the middle of ACCUM.
    batch_q = {};
    open_batch();
    set_rec(mk(11, 4, 0, 0, 0, 0), 1'b0);
    sel_if.in_valid = 1;
    tick();
    set_rec(mk(12, 3, 0, 0, 0, 0), 1'b0);
    tick();
    #2 ARESETN = 0;
    #1;
    chk("arst busy", sel_if.busy, 0);
    chk("arst in_ready", sel_if.in_ready, 0);
    chk("arst res_valid", sel_if.res_valid, 0);
    chk("arst res_count", sel_if.res_count, 0);
    chk("arst res_found", sel_if.res_found, 0);
    chk("arst res_move_id", sel_if.res_move_id, 0);
    chk("arst res_score", sel_if.res_score, 0);
    sel_if.in_valid = 0;
    #2 ARESETN = 1;
    tick();
    chk("arst idle after release", sel_if.busy, 0);
    batch_q = {mk(2, 1, 1, 1, 1, 0)};
    run_batch("post_reset", 1'b1, cyc);
    chk("post_reset move_id", sel_if.res_move_id, 2);
    check_res("post_reset");
    release_res(0);

    // Randomized batches against the model.
    for (int b = 0; b < 25; b++) begin
      int n;
      bit wide;
      wl  = int'($urandom_range(0, 65535)) - 32768;
      wh  = int'($urandom_range(0, 65535)) - 32768;
      wht = int'($urandom_range(0, 65535)) - 32768;
      wb  = int'($urandom_range(0, 65535)) - 32768;
      wide = (b % 3 == 0);
      n = $urandom_range(1, 20);
      batch_q = {};
      for (int i = 0; i < n; i++) begin
        if (wide)
          batch_q.push_back(mk($urandom_range(0, 63), $urandom_range(0, MAX_LINES),
                               $urandom_range(0, 255), $urandom_range(0, 255),
                               $urandom_range(0, 255), $urandom_range(0, 3) == 0));
        else
          batch_q.push_back(mk($urandom_range(0, 63), $urandom_range(0, 1),
                               $urandom_range(0, 1), $urandom_range(0, 2),
                               $urandom_range(0, 1), $urandom_range(0, 3) == 0));
      end
      run_batch($sformatf("rand%0d", b), b[0], cyc);
      check_res($sformatf("rand%0d", b));
      release_res($urandom_range(0, 3));
      chk($sformatf("rand%0d idle", b), sel_if.busy, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
